// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a ready/data/busy handshake.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_wr_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  input  logic                     i_clr_ovf,
  output logic                     o_tx_rdy,
  output logic [7:0]               o_tx_data,
  input  logic                     i_tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  state_t        state_q, state_d;
  logic          tx_rdy_q, tx_rdy_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic          wr_accept;
  logic          pop;

  // Acceptance uses the registered full flag, so a pop in the same cycle
  // never makes room for a write that arrived while full.
  assign wr_accept = i_wr_en && !full_q;
  assign pop       = (state_q == IDLE) && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= i_wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_rdy_d  = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          tx_data_d = mem[rd_ptr_q];
          tx_rdy_d  = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The start pulse is registered so it is high exactly while in LAUNCH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      tx_rdy_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_rdy_q  <= tx_rdy_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (i_wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = i_clr_ovf;
  assign o_overflow     = 1'b0;
`endif

  assign o_full    = full_q;
  assign o_empty   = empty_q;
  assign o_level   = count_q;
  assign o_tx_rdy  = tx_rdy_q;
  assign o_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter model.
// Expected bytes are queued at write time and checked on each o_tx_rdy pulse.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int FRAME = 4;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        empty;
  logic [4:0]  level;
  logic        overflow;
  logic        clr_ovf;
  logic        tx_rdy;
  logic [7:0]  tx_data;
  logic        tx_busy;

  logic        pend;
  logic [3:0]  fcnt;
  logic        hold_busy;

  logic [7:0]  exp_q [$];
  logic [7:0]  cur_data;
  logic        prev_rdy;
  int          errors;
  int          checks;
  logic        exp_ovf;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .o_full     (full),
    .o_empty    (empty),
    .o_level    (level),
    .o_overflow (overflow),
    .i_clr_ovf  (clr_ovf),
    .o_tx_rdy   (tx_rdy),
    .o_tx_data  (tx_data),
    .i_tx_busy  (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter: samples the start pulse while idle, raises busy one cycle
  // later, and optionally stalls at the end of the frame while hold_busy is set.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      tx_busy <= 1'b0;
      fcnt    <= '0;
    end else if (pend) begin
      pend    <= 1'b0;
      tx_busy <= 1'b1;
      fcnt    <= 4'(FRAME);
    end else if (tx_busy) begin
      if (fcnt != 0) fcnt <= fcnt - 1'b1;
      else if (!hold_busy) tx_busy <= 1'b0;
    end else if (tx_rdy) begin
      pend <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (exp_q.size() == 0 && empty && !tx_busy && !pend && !tx_rdy) break;
      @(negedge clk);
    end
    if (k == budget) checkOutput("drain_timeout", 32'(k), 32'(budget - 1));
  endtask

  // Monitor: compares every launched byte against the scoreboard head and
  // checks the pulse is single-cycle, never overlaps busy, and data is held.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_rdy) begin
        checkOutput("rdy_while_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("rdy_width", {31'd0, prev_rdy}, 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", {24'd0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
        cur_data = tx_data;
      end else if (tx_busy) begin
        checkOutput("tx_data_hold", {24'd0, tx_data}, {24'd0, cur_data});
      end
      prev_rdy = tx_rdy;
    end else begin
      prev_rdy = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    errors    = 0;
    checks    = 0;
    prev_rdy  = 1'b0;
    cur_data  = 8'h00;
    hold_busy = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    clr_ovf   = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    rst_n = 1'b0;
    idleCycles(3);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("rst_empty", {31'd0, empty}, 32'd1);
    checkOutput("rst_full", {31'd0, full}, 32'd0);
    checkOutput("rst_level", {27'd0, level}, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("rst_rdy", {31'd0, tx_rdy}, 32'd0);
    checkOutput("rst_data", {24'd0, tx_data}, 32'h00);

    // Single byte: level 0->1->0 and pulse in the cycle after the write edge.
    applyStimulus(8'hA5, 1'b1);
    checkOutput("t1_level_after_wr", {27'd0, level}, 32'd1);
    checkOutput("t1_rdy_early", {31'd0, tx_rdy}, 32'd0);
    @(negedge clk);
    checkOutput("t1_level_after_pop", {27'd0, level}, 32'd0);
    checkOutput("t1_rdy_pulse", {31'd0, tx_rdy}, 32'd1);
    @(negedge clk);
    checkOutput("t1_rdy_low", {31'd0, tx_rdy}, 32'd0);
    waitDrain(200);

    // Four bytes back-to-back.
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1);
    waitDrain(400);

    // Fill with the transmitter stalled: first byte is in flight, 16 remain.
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) applyStimulus(8'h10 + 8'(i), 1'b1);
    idleCycles(2);
    checkOutput("fill_level", {27'd0, level}, 32'd16);
    checkOutput("fill_full", {31'd0, full}, 32'd1);
    checkOutput("fill_ovf_pre", {31'd0, overflow}, 32'd0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("fill_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
    checkOutput("fill_level_drop", {27'd0, level}, 32'd16);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Hold a write at full across the pop edge: it must be dropped.
    hold_busy = 1'b0;
    wr_en     = 1'b1;
    wr_data   = 8'hEE;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_rdy) break;
    end
    wr_en = 1'b0;
    if (k == 200) checkOutput("pop_timeout", 32'(k), 32'd0);
    checkOutput("popwr_level", {27'd0, level}, 32'd15);
    checkOutput("popwr_full", {31'd0, full}, 32'd0);
    waitDrain(3000);
    checkOutput("drained_empty", {31'd0, empty}, 32'd1);

    // Twenty bytes spaced out while draining; pointers wrap past DEPTH.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'h80 + 8'(i), 1'b1);
      idleCycles(3);
    end
    waitDrain(3000);
    checkOutput("wrap_level", {27'd0, level}, 32'd0);

    // Reset while the transmitter is mid-frame with 5 bytes still queued.
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(8'hC0 + 8'(i), 1'b1);
    idleCycles(8);
    checkOutput("pre_rst_level", {27'd0, level}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_empty", {31'd0, empty}, 32'd1);
    checkOutput("arst_level", {27'd0, level}, 32'd0);
    checkOutput("arst_rdy", {31'd0, tx_rdy}, 32'd0);
    exp_q.delete();
    hold_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(30);
    applyStimulus(8'h5A, 1'b1);
    waitDrain(200);
    checkOutput("final_empty", {31'd0, empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
